// File: rtl/game_status_ctrl_pkg.sv
// Shared types and defaults for the game supervisor and its score counter.
// State encoding is visible on o_State, so the values are fixed.
package game_status_ctrl_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HIT  = 2'd2,
      ST_OVER = 2'd3
   } state_e;

   localparam int NUM_PIPES_DEF  = 3;
   localparam int HIT_FRAMES_DEF = 60;
   localparam int SCORE_MAX_DEF  = 99;
   localparam int BCD_W          = 4;
endpackage

// File: rtl/game_status_ctrl_if.sv
// Draw/tick inputs and status outputs of game_status_ctrl, grouped as one bundle.
// Signal names are taken from the supervisor's point of view.
interface game_status_ctrl_if #(parameter int NUM_PIPES = 3);
   import game_status_ctrl_pkg::*;

   logic                 i_Start;
   logic                 i_Frame_End;
   logic                 i_Draw_Bird;
   logic [NUM_PIPES-1:0] i_Draw_Pipe;
   logic [NUM_PIPES-1:0] i_Done_Tick;
   logic                 o_Run;
   logic [1:0]           o_State;
   logic                 o_Collision;
   logic                 o_Game_Over;
   logic [BCD_W-1:0]     o_Score_Ones;
   logic [BCD_W-1:0]     o_Score_Tens;

   modport master (
      output i_Start, i_Frame_End, i_Draw_Bird, i_Draw_Pipe, i_Done_Tick,
      input  o_Run, o_State, o_Collision, o_Game_Over, o_Score_Ones, o_Score_Tens
   );

   modport slave (
      input  i_Start, i_Frame_End, i_Draw_Bird, i_Draw_Pipe, i_Done_Tick,
      output o_Run, o_State, o_Collision, o_Game_Over, o_Score_Ones, o_Score_Tens
   );
endinterface

// File: rtl/game_status_ctrl_bcd_score_counter.sv
// Two-digit BCD accumulator that saturates at SCORE_MAX.
// Increment must not exceed 10, so one ones->tens carry is always enough.
module bcd_score_counter
   import game_status_ctrl_pkg::*;
#(
   parameter int INC_W     = 2,
   parameter int SCORE_MAX = SCORE_MAX_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             en_i,
   input  logic [INC_W-1:0] inc_i,
   output logic [BCD_W-1:0] ones_o,
   output logic [BCD_W-1:0] tens_o
);
   localparam int SW = BCD_W + 1;
   localparam logic [BCD_W-1:0] MAX_ONES = BCD_W'(SCORE_MAX % 10);
   localparam logic [BCD_W-1:0] MAX_TENS = BCD_W'(SCORE_MAX / 10);

   logic [BCD_W-1:0] ones_q, tens_q, ones_d, tens_d;
   logic [SW-1:0]    ones_sum, ones_wrap, tens_sum;
   logic             carry, sat;

   always_comb begin
      ones_sum  = {1'b0, ones_q} + SW'(inc_i);
      carry     = (ones_sum >= SW'(10));
      ones_wrap = carry ? (ones_sum - SW'(10)) : ones_sum;
      tens_sum  = {1'b0, tens_q} + SW'(carry);
      sat       = (tens_sum > {1'b0, MAX_TENS}) ||
                  ((tens_sum == {1'b0, MAX_TENS}) && (ones_wrap > {1'b0, MAX_ONES}));
      ones_d    = ones_q;
      tens_d    = tens_q;
      if (clear_i) begin
         ones_d = '0;
         tens_d = '0;
      end else if (en_i) begin
         ones_d = sat ? MAX_ONES : ones_wrap[BCD_W-1:0];
         tens_d = sat ? MAX_TENS : tens_sum[BCD_W-1:0];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ones_q <= '0;
         tens_q <= '0;
      end else begin
         ones_q <= ones_d;
         tens_q <= tens_d;
      end
   end

   assign ones_o = ones_q;
   assign tens_o = tens_q;
endmodule

// File: rtl/game_status_ctrl.sv
// Game supervisor: IDLE/RUN/HIT/OVER sequencing, frame-synchronous collision
// decision, HIT freeze timing and the saturating BCD score.
module game_status_ctrl
   import game_status_ctrl_pkg::*;
#(
   parameter int NUM_PIPES  = NUM_PIPES_DEF,
   parameter int HIT_FRAMES = HIT_FRAMES_DEF,
   parameter int SCORE_MAX  = SCORE_MAX_DEF
) (
   input  logic              i_Clk,
   input  logic              i_Reset,
   game_status_ctrl_if.slave bus
);
   localparam int CNT_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;
   localparam int INC_W = $clog2(NUM_PIPES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HIT_FRAMES - 1);

   state_e           state_q;
   logic             run_q, hit_q, coll_q, go_q;
   logic [CNT_W-1:0] cnt_q;
   logic [INC_W-1:0] tick_cnt;
   logic             overlap, start_ok;

   always_comb begin
      tick_cnt = '0;
      for (int p = 0; p < NUM_PIPES; p++)
         tick_cnt = tick_cnt + INC_W'(bus.i_Done_Tick[p]);
   end

   assign overlap  = bus.i_Draw_Bird && (|bus.i_Draw_Pipe);
   assign start_ok = bus.i_Start && ((state_q == ST_IDLE) || (state_q == ST_OVER));

   // o_Collision trails the internal hit flag by one cycle; the state only
   // changes on frame end so a frame is never rendered half-frozen.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_q <= ST_IDLE;
         run_q   <= 1'b0;
         hit_q   <= 1'b0;
         coll_q  <= 1'b0;
         go_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         go_q   <= 1'b0;
         coll_q <= hit_q;
         case (state_q)
            ST_IDLE, ST_OVER: begin
               if (bus.i_Start) begin
                  state_q <= ST_RUN;
                  run_q   <= 1'b1;
                  hit_q   <= 1'b0;
                  coll_q  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (overlap) hit_q <= 1'b1;
               if (bus.i_Frame_End && (hit_q || overlap)) begin
                  state_q <= ST_HIT;
                  run_q   <= 1'b0;
                  cnt_q   <= '0;
               end
            end
            ST_HIT: begin
               if (bus.i_Frame_End) begin
                  if (cnt_q == CNT_LAST) begin
                     state_q <= ST_OVER;
                     go_q    <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   bcd_score_counter #(
      .INC_W     (INC_W),
      .SCORE_MAX (SCORE_MAX)
   ) u_score (
      .clk_i   (i_Clk),
      .rst_i   (i_Reset),
      .clear_i (start_ok),
      .en_i    (state_q == ST_RUN),
      .inc_i   (tick_cnt),
      .ones_o  (bus.o_Score_Ones),
      .tens_o  (bus.o_Score_Tens)
   );

   assign bus.o_State     = state_q;
   assign bus.o_Run       = run_q;
   assign bus.o_Collision = coll_q;
   assign bus.o_Game_Over = go_q;
endmodule

// File: tb/tb_game_status_ctrl.sv
// Scoreboard bench for game_status_ctrl: directed game scenarios plus random
// play, checked against an integer-level game model.
module tb_game_status_ctrl;
   import game_status_ctrl_pkg::*;

   localparam int NP = 3, HF = 60, SMAX = 99;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   game_status_ctrl_if #(.NUM_PIPES(NP)) bus();

   game_status_ctrl #(.NUM_PIPES(NP), .HIT_FRAMES(HF), .SCORE_MAX(SMAX)) dut (
      .i_Clk   (clk),
      .i_Reset (rst),
      .bus     (bus)
   );

   typedef struct {
      int st;
      bit run;
      bit coll;
      bit go;
      int score;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // model: 0 idle, 1 run, 2 hit, 3 over
   int m_st = 0, m_score = 0, m_frames = 0;
   bit m_hit = 1'b0;

   task automatic model_reset();
      m_st = 0; m_score = 0; m_frames = 0; m_hit = 1'b0;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic step(input bit s, input bit fe, input bit b,
                       input logic [NP-1:0] p, input logic [NP-1:0] d);
      exp_t e;
      bit   ov, coll, go;
      int   n;
      @(negedge clk);
      bus.i_Start = s; bus.i_Frame_End = fe; bus.i_Draw_Bird = b;
      bus.i_Draw_Pipe = p; bus.i_Done_Tick = d;
      ov   = b && (p != '0);
      n    = $countones(d);
      coll = m_hit;
      go   = 1'b0;
      case (m_st)
         0, 3: if (s) begin m_st = 1; m_score = 0; m_hit = 1'b0; coll = 1'b0; end
         1: begin
            m_score = (m_score + n > SMAX) ? SMAX : m_score + n;
            if (ov) m_hit = 1'b1;
            if (fe && m_hit) begin m_st = 2; m_frames = 0; end
         end
         default: if (fe) begin
            if (m_frames == HF - 1) begin m_st = 3; go = 1'b1; end
            else m_frames++;
         end
      endcase
      e.st = m_st; e.run = (m_st == 1); e.coll = coll; e.go = go; e.score = m_score;
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         idle(2);
         step(0, 1, 0, '0, '0);
      end
   endtask

   // Monitor: compare every cycle that has a pending expectation
   initial begin
      exp_t e;
      int   act_score;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            act_score = int'(bus.o_Score_Tens) * 10 + int'(bus.o_Score_Ones);
            checks++;
            if (int'(bus.o_State) != e.st || bus.o_Run != e.run || bus.o_Collision != e.coll ||
                bus.o_Game_Over != e.go || act_score != e.score || bus.o_Score_Ones > 4'd9) begin
               errors++;
               $display("FAIL sb@%0t state %0d want %0d run %0b want %0b coll %0b want %0b go %0b want %0b score %0d%0d want %0d",
                        $time, bus.o_State, e.st, bus.o_Run, e.run, bus.o_Collision, e.coll,
                        bus.o_Game_Over, e.go, bus.o_Score_Tens, bus.o_Score_Ones, e.score);
            end
         end
      end
   end

   initial begin
      bus.i_Start = 0; bus.i_Frame_End = 0; bus.i_Draw_Bird = 0;
      bus.i_Draw_Pipe = '0; bus.i_Done_Tick = '0;
      #22;
      chk("rst_state", int'(bus.o_State), 0);
      chk("rst_run",   int'(bus.o_Run), 0);
      chk("rst_coll",  int'(bus.o_Collision), 0);
      chk("rst_go",    int'(bus.o_Game_Over), 0);
      chk("rst_ones",  int'(bus.o_Score_Ones), 0);
      chk("rst_tens",  int'(bus.o_Score_Tens), 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // Idle ignores ticks; start enters RUN
      step(0, 0, 0, '0, 3'b111);
      step(1, 0, 0, '0, '0);
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 0, '0, 3'b010);
         step(0, (i % 4) == 3, 0, '0, '0);
      end
      step(0, 0, 0, '0, 3'b111);
      // Walk up to 98, then saturate
      for (int i = 0; i < 83; i++) step(0, 0, 0, '0, 3'b001);
      step(0, 0, 0, '0, 3'b111);
      step(0, 0, 0, '0, 3'b100);
      // Mid-frame collision, freeze, ignored start in HIT, game over
      idle(2);
      step(0, 0, 1, 3'b100, '0);
      idle(3);
      step(0, 1, 0, '0, '0);
      step(1, 0, 0, '0, 3'b111);
      frames(HF);
      idle(3);

      // Second game: 7 points, collision on the frame-end cycle with a tick
      step(1, 0, 0, '0, '0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, '0, 3'b001);
      step(0, 1, 1, 3'b010, 3'b001);
      frames(HF);
      step(0, 0, 0, '0, 3'b111);
      step(0, 0, 0, '0, 3'b011);
      step(1, 0, 0, '0, 3'b111);
      idle(2);

      // Third game: async reset mid-frame with score 05
      for (int i = 0; i < 5; i++) step(0, 0, 0, '0, 3'b001);
      idle(1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_state", int'(bus.o_State), 0);
      chk("arst_run",   int'(bus.o_Run), 0);
      chk("arst_ones",  int'(bus.o_Score_Ones), 0);
      chk("arst_tens",  int'(bus.o_Score_Tens), 0);
      chk("arst_coll",  int'(bus.o_Collision), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      step(0, 1, 0, '0, 3'b001);
      idle(2);
      step(1, 0, 0, '0, '0);

      // Random play
      for (int i = 0; i < 4000; i++) begin
         logic [NP-1:0] d;
         for (int k = 0; k < NP; k++) d[k] = ($urandom % 6) == 0;
         step(($urandom % 60) == 0, ($urandom % 6) == 0, ($urandom % 12) == 0,
              NP'($urandom), d);
      end
      idle(1);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #2;
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain pending %0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
